far_pointer_loader: RTL and testbench

FAR_POINTER_LOADER -- requirements
Module: far_pointer_loader

---
 rtl/far_pointer_loader.sv | 152 +++++++++++++++
 tb/tb_far_pointer_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/far_pointer_loader.sv
// -----------------------------------------------------------------------------
// far_pointer_loader
//
// Loads a far pointer (offset word, then segment word) from memory. The offset
// is captured into ptr_off, and the segment word is written to the segment
// register file selected by seg_sel. The segment word is read from base_off+2,
// with the offset wrapping inside the segment. Loading SS also raises
// irq_inhibit for the write-back cycle.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        load request, accepted in IDLE and in the write-back cycle
//   seg_sel      target segment register (ES=0, CS=1, SS=2, DS=3)
//   base_seg     segment of the memory operand
//   base_off     offset of the memory operand
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse (the write-back cycle)
//   ptr_off      loaded offset word, held until the next load reads it
//   m_access     memory read request, held until m_ack
//   m_addr       20-bit physical word address of the pending read
//   m_ack        read completes this cycle
//   m_data_in    read data, valid with m_ack
//   seg_wr_en    segment register file write enable
//   seg_wr_sel   segment register file write select
//   seg_wr_val   segment register file write data
//   irq_inhibit  one-cycle pulse when SS is written
// -----------------------------------------------------------------------------
module far_pointer_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  seg_sel,
    input  logic [15:0] base_seg,
    input  logic [15:0] base_off,
    output logic        busy,
    output logic        done,
    output logic [15:0] ptr_off,
    output logic        m_access,
    output logic [19:0] m_addr,
    input  logic        m_ack,
    input  logic [15:0] m_data_in,
    output logic        seg_wr_en,
    output logic [1:0]  seg_wr_sel,
    output logic [15:0] seg_wr_val,
    output logic        irq_inhibit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_OFF = 2'd1,
        RD_SEG = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [1:0] SEG_SS = 2'd2;

    state_t      state;
    state_t      state_next;
    logic [1:0]  sel_q;
    logic [15:0] seg_q;
    logic [15:0] off_q;
    logic        accept;
    logic [19:0] phys_base;
    logic [15:0] off_plus2;
    logic [19:0] addr_off;
    logic [19:0] addr_seg;

    // The write-back cycle also accepts a new request so loads can run
    // back to back without an idle gap.
    assign accept = start && ((state == IDLE) || (state == WB));

    // 20-bit adders wrap the physical address; the 16-bit add keeps the
    // second read inside the segment.
    assign phys_base = {seg_q, 4'h0};
    assign off_plus2 = off_q + 16'd2;
    assign addr_off  = phys_base + {4'h0, off_q};
    assign addr_seg  = phys_base + {4'h0, off_plus2};

    // NOTE: state and data registers use non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel_q      <= 2'd0;
            seg_q      <= 16'h0000;
            off_q      <= 16'h0000;
            ptr_off    <= 16'h0000;
            seg_wr_val <= 16'h0000;
        end else begin
            state <= state_next;
            if (accept) begin
                sel_q <= seg_sel;
                seg_q <= base_seg;
                off_q <= base_off;
            end
            if ((state == RD_OFF) && m_ack) begin
                ptr_off <= m_data_in;
            end
            if ((state == RD_SEG) && m_ack) begin
                seg_wr_val <= m_data_in;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        busy        = 1'b1;
        done        = 1'b0;
        m_access    = 1'b0;
        m_addr      = 20'h00000;
        seg_wr_en   = 1'b0;
        seg_wr_sel  = 2'd0;
        irq_inhibit = 1'b0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_next = RD_OFF;
                end
            end
            RD_OFF: begin
                m_access = 1'b1;
                m_addr   = addr_off;
                if (m_ack) begin
                    state_next = RD_SEG;
                end
            end
            RD_SEG: begin
                m_access = 1'b1;
                m_addr   = addr_seg;
                if (m_ack) begin
                    state_next = WB;
                end
            end
            WB: begin
                done        = 1'b1;
                seg_wr_en   = 1'b1;
                seg_wr_sel  = sel_q;
                irq_inhibit = (sel_q == SEG_SS);
                state_next  = accept ? RD_OFF : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_far_pointer_loader.sv
// -----------------------------------------------------------------------------
// tb_far_pointer_loader
//
// Scoreboard bench for far_pointer_loader. Each issued load pushes its
// expected read addresses, memory words, wait states and completion record
// into queues. A memory responder pops addresses/words/waits as reads appear,
// and a monitor pops completion records whenever done is seen.
// -----------------------------------------------------------------------------
module tb_far_pointer_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  seg_sel;
    logic [15:0] base_seg;
    logic [15:0] base_off;
    logic        busy;
    logic        done;
    logic [15:0] ptr_off;
    logic        m_access;
    logic [19:0] m_addr;
    logic        m_ack;
    logic [15:0] m_data_in;
    logic        seg_wr_en;
    logic [1:0]  seg_wr_sel;
    logic [15:0] seg_wr_val;
    logic        irq_inhibit;

    far_pointer_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seg_sel     (seg_sel),
        .base_seg    (base_seg),
        .base_off    (base_off),
        .busy        (busy),
        .done        (done),
        .ptr_off     (ptr_off),
        .m_access    (m_access),
        .m_addr      (m_addr),
        .m_ack       (m_ack),
        .m_data_in   (m_data_in),
        .seg_wr_en   (seg_wr_en),
        .seg_wr_sel  (seg_wr_sel),
        .seg_wr_val  (seg_wr_val),
        .irq_inhibit (irq_inhibit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ptr;
        logic [1:0]  sel;
        logic [15:0] val;
        logic        irq;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [19:0] addr_q[$];
    logic [15:0] data_q[$];
    int          wait_q[$];

    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          seg_writes = 0;
    int          n_issued   = 0;
    int          n_aborted  = 0;
    logic [15:0] last_ptr   = 16'h0000;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference address: segment * 16 plus the k-th word offset, with the
    // offset wrapping at 64K and the sum wrapping at 1M.
    function automatic logic [19:0] phys(input int seg, input int off, input int k);
        int a;
        a = seg * 16 + ((off + 2 * k) % 65536);
        return 20'(a % 1048576);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called one time unit after a rising edge, with the DUT in IDLE or WB.
    task automatic start_load(input logic [1:0] sel, input logic [15:0] seg,
                              input logic [15:0] off, input logic [15:0] w0,
                              input logic [15:0] w1, input int n0, input int n1);
        exp_t e;
        check("ptr_hold", 32'(ptr_off), 32'(last_ptr));
        start    = 1'b1;
        seg_sel  = sel;
        base_seg = seg;
        base_off = off;
        addr_q.push_back(phys(int'(seg), int'(off), 0));
        addr_q.push_back(phys(int'(seg), int'(off), 1));
        data_q.push_back(w0);
        data_q.push_back(w1);
        wait_q.push_back(n0);
        wait_q.push_back(n1);
        e.ptr      = w0;
        e.sel      = sel;
        e.val      = w1;
        e.irq      = (sel == 2'd2);
        e.done_cyc = cyc + 3 + n0 + n1;
        exp_q.push_back(e);
        last_ptr = w0;
        n_issued++;
        @(posedge clk);
        #1;
        start    = 1'b0;
        seg_sel  = 2'($urandom);
        base_seg = 16'($urandom);
        base_off = 16'($urandom);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_wait_bound", 0, 1);
    endtask

    task automatic finish_load(output bit in_wb);
        if (done) in_wb = 1'b1;
        else wait_done(in_wb);
    endtask

    task automatic wait_rd_seg(input logic [19:0] a1, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (m_access && (m_addr == a1)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rd_seg_wait_bound", 0, 1);
    endtask

    task automatic pulse_start_garbage();
        start    = 1'b1;
        seg_sel  = 2'($urandom);
        base_seg = 16'($urandom);
        base_off = 16'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Memory responder: checks each new read address against the model,
    // holds m_ack low for the planned wait cycles, and checks m_addr stays
    // put while waiting. Outside reads it toggles m_ack randomly.
    initial begin : responder
        bit          pending;
        int          cnt;
        logic [19:0] req_addr;
        pending   = 1'b0;
        cnt       = 0;
        req_addr  = 20'h0;
        m_ack     = 1'b0;
        m_data_in = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (reset || !m_access) begin
                pending   = 1'b0;
                m_ack     = 1'($urandom_range(0, 1));
                m_data_in = 16'($urandom);
            end else begin
                if (!pending) begin
                    pending  = 1'b1;
                    req_addr = m_addr;
                    if ((addr_q.size() == 0) || (wait_q.size() == 0)) begin
                        check("read_unexpected", 0, 1);
                        cnt = 0;
                    end else begin
                        check("m_addr", 32'(m_addr), 32'(addr_q.pop_front()));
                        cnt = wait_q.pop_front();
                    end
                end else begin
                    check("m_addr_stable", 32'(m_addr), 32'(req_addr));
                end
                if (cnt == 0) begin
                    m_ack     = 1'b1;
                    m_data_in = (data_q.size() > 0) ? data_q.pop_front() : 16'hDEAD;
                    pending   = 1'b0;
                end else begin
                    cnt--;
                    m_ack     = 1'b0;
                    m_data_in = 16'($urandom);
                end
            end
        end
    end

    // Completion monitor.
    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (seg_wr_en) seg_writes++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", 0, 1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
                        check("busy_in_wb", 32'(busy), 1);
                        check("seg_wr_en", 32'(seg_wr_en), 1);
                        check("ptr_off", 32'(ptr_off), 32'(mon_e.ptr));
                        check("seg_wr_sel", 32'(seg_wr_sel), 32'(mon_e.sel));
                        check("seg_wr_val", 32'(seg_wr_val), 32'(mon_e.val));
                        check("irq_inhibit", 32'(irq_inhibit), 32'(mon_e.irq));
                    end
                end else begin
                    check("wr_en_outside_wb", 32'(seg_wr_en), 0);
                    check("irq_outside_wb", 32'(irq_inhibit), 0);
                    if ((exp_q.size() > 0) && (cyc > exp_q[0].done_cyc)) begin
                        check("done_late", 0, 1);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       32'(busy), 0);
        check({tag, "_done"},       32'(done), 0);
        check({tag, "_m_access"},   32'(m_access), 0);
        check({tag, "_m_addr"},     32'(m_addr), 0);
        check({tag, "_seg_wr_en"},  32'(seg_wr_en), 0);
        check({tag, "_irq"},        32'(irq_inhibit), 0);
        check({tag, "_ptr_off"},    32'(ptr_off), 0);
        check({tag, "_seg_wr_sel"}, 32'(seg_wr_sel), 0);
        check({tag, "_seg_wr_val"}, 32'(seg_wr_val), 0);
    endtask

    initial begin : stimulus
        bit          ok;
        bit          in_wb;
        logic [15:0] rs;
        logic [15:0] ro;
        reset    = 1'b1;
        start    = 1'b0;
        seg_sel  = 2'd0;
        base_seg = 16'h0000;
        base_off = 16'h0000;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Zero-wait DS load.
        start_load(2'd3, 16'h1000, 16'h0020, 16'h1234, 16'hABCD, 0, 0);
        wait_done(ok);
        idle(1);
        check("idle_after_done", 32'(busy), 0);

        // Offset wraps inside the segment, ES target.
        start_load(2'd0, 16'h2000, 16'hFFFF, 16'($urandom), 16'($urandom), 0, 1);
        wait_done(ok);
        idle(1);

        // Physical address wraps at 1M, CS target.
        start_load(2'd1, 16'hFFFF, 16'h0010, 16'($urandom), 16'($urandom), 1, 0);
        wait_done(ok);
        idle(1);

        // Two wait states per read, SS target.
        start_load(2'd2, 16'h3456, 16'h789A, 16'($urandom), 16'($urandom), 2, 2);
        wait_done(ok);
        idle(1);

        // Start during RD_SEG is dropped; start in WB chains the next load.
        start_load(2'd1, 16'h4000, 16'h0100, 16'h1111, 16'h2222, 0, 0);
        wait_rd_seg(phys(32'h4000, 32'h0100, 1), ok);
        pulse_start_garbage();
        check("wb_after_ignored_start", 32'(done), 1);
        start_load(2'd3, 16'h5000, 16'h0200, 16'h3333, 16'h4444, 0, 0);
        wait_done(ok);
        idle(1);

        // Reset while waiting in RD_SEG abandons the load.
        start_load(2'd2, 16'h6000, 16'h0300, 16'h5555, 16'h6666, 1, 2);
        wait_rd_seg(phys(32'h6000, 32'h0300, 1), ok);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        addr_q.delete();
        data_q.delete();
        wait_q.delete();
        last_ptr = 16'h0000;
        n_aborted++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        start_load(2'd0, 16'h7000, 16'h0400, 16'h7777, 16'h8888, 0, 1);
        wait_done(ok);
        idle(1);

        // Randomized loads with random waits, gaps, chaining and stray starts.
        in_wb = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!(in_wb && ($urandom_range(0, 1) == 1))) begin
                if (in_wb) idle(1);
                idle($urandom_range(0, 2));
            end
            rs = 16'($urandom);
            ro = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
            start_load(2'($urandom), rs, ro, 16'($urandom), 16'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
                if (busy && !done) pulse_start_garbage();
            end
            finish_load(in_wb);
        end
        if (in_wb) idle(1);
        idle(3);

        check("final_idle", 32'(busy), 0);
        check("seg_write_count", 32'(seg_writes), 32'(n_issued - n_aborted));
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
